snake_move_ctrl: RTL and testbench

Sequences snake head movement for the VGA snake game: arbitrates the four active-low direction keys, rejects 180-degree reversals, generates the periodic move tick, and advances and wraps the head grid position on each tick. Sits between the debounced key inputs and the body/collision/draw logic. That logic consumes move_tick, direction and head_x/head_y, and returns game_over.

---
 rtl/snake_move_ctrl.sv | 159 +++++++++++++++
 tb/tb_snake_move_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_ctrl.sv
// Snake head movement sequencer: arbitrates the active-low direction keys,
// rejects 180-degree reversals against the committed direction, divides
// VGA_CLK down to the move tick and advances/wraps the head on each tick.
module snake_move_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int X0       = 20,
  parameter int Y0       = 15,
  parameter int TICK_DIV = 2500000
) (
  input  logic           VGA_CLK,
  input  logic           reset,
  input  logic           sw0,
  input  logic           sw1,
  input  logic           sw2,
  input  logic           sw3,
  input  logic           pause,
  input  logic           game_over,
  input  logic           restart,
  output logic [2:0]     direction,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic           move_tick,
  output logic           running,
  output logic           halted
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] X_INIT  = X_W'(X0);
  localparam logic [Y_W-1:0] Y_INIT  = Y_W'(Y0);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  state_t         state_q, state_d;
  dir_t           dir_q, dir_d;
  dir_t           pend_q, pend_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tick_q, tick_d;
  logic           running_q, running_d;
  logic           halted_q, halted_d;
  dir_t           req;

  function automatic logic is_opposite(dir_t a, dir_t b);
    return ((a == DIR_UP)   && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN) && (b == DIR_UP))    ||
           ((a == DIR_LEFT) && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

  // Fixed-priority key decode: up > down > left > right.
  always_comb begin
    req = DIR_NONE;
    if (!sw0)      req = DIR_UP;
    else if (!sw1) req = DIR_DOWN;
    else if (!sw2) req = DIR_LEFT;
    else if (!sw3) req = DIR_RIGHT;
  end

  // Next-state logic for the FSM, request latch, tick divider and head position.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (restart) begin
      state_d = IDLE;
      dir_d   = DIR_NONE;
      pend_d  = DIR_NONE;
      x_d     = X_INIT;
      y_d     = Y_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (req != DIR_NONE) begin
            pend_d  = req;
            state_d = RUN;
          end
        end
        RUN: begin
          if ((req != DIR_NONE) && !is_opposite(req, dir_q)) pend_d = req;
          // game_over outranks a coincident tick: head and direction stay put.
          if (game_over) begin
            state_d = HALT;
          end else if (!pause) begin
            if (cnt_q == CNT_MAX) begin
              cnt_d  = '0;
              tick_d = 1'b1;
              dir_d  = pend_q;
              case (pend_q)
                DIR_UP:    y_d = (y_q == '0)    ? Y_MAX : y_q - 1'b1;
                DIR_DOWN:  y_d = (y_q == Y_MAX) ? '0    : y_q + 1'b1;
                DIR_LEFT:  x_d = (x_q == '0)    ? X_MAX : x_q - 1'b1;
                DIR_RIGHT: x_d = (x_q == X_MAX) ? '0    : x_q + 1'b1;
                default: ;
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    running_d = (state_d == RUN);
    halted_d  = (state_d == HALT);
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_NONE;
      pend_q    <= DIR_NONE;
      x_q       <= X_INIT;
      y_q       <= Y_INIT;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  assign direction = dir_q;
  assign head_x    = x_q;
  assign head_y    = y_q;
  assign move_tick = tick_q;
  assign running   = running_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl on an 8x6 grid with a 4-cycle move period.
module tb_snake_move_ctrl;
  localparam int GW = 8, GH = 6, X0 = 4, Y0 = 3, TD = 4;

  logic       VGA_CLK = 1'b0;
  logic       reset = 1'b0;
  logic       sw0 = 1'b1, sw1 = 1'b1, sw2 = 1'b1, sw3 = 1'b1;
  logic       pause = 1'b0, game_over = 1'b0, restart = 1'b0;
  logic [2:0] direction;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic       move_tick, running, halted;

  snake_move_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .X_W(3), .Y_W(3), .X0(X0), .Y0(Y0), .TICK_DIV(TD)
  ) dut (
    .VGA_CLK(VGA_CLK), .reset(reset),
    .sw0(sw0), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .pause(pause), .game_over(game_over), .restart(restart),
    .direction(direction), .head_x(head_x), .head_y(head_y),
    .move_tick(move_tick), .running(running), .halted(halted)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  typedef struct {int dir; int x; int y; int cyc;} exp_t;
  exp_t sb[$];

  int n_assert = 0, n_fail = 0;
  int cyc = 0, ticks_seen = 0, ticks_exp = 0;
  bit tick_now = 0, prev_tick = 0;
  // reference model of the committed/pending direction and head
  int m_dir, m_pend, m_x, m_y, next_tick;
  bit m_run, m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge VGA_CLK);
    cyc++;
    tick_now = move_tick;
    if (tick_now) ticks_seen++;
    if (tick_now && prev_tick) check("tick_back_to_back", 32'd1, 32'd0);
    prev_tick = tick_now;
  endtask

  function automatic bit opp(int a, int b);
    return (a == 1 && b == 2) || (a == 2 && b == 1) || (a == 3 && b == 4) || (a == 4 && b == 3);
  endfunction

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_dir = 0; m_pend = 0; m_x = X0; m_y = Y0;
  endtask

  // k[0..3] = sw0..sw3 pressed for one cycle
  task automatic press(input logic [3:0] k);
    int req;
    req = k[0] ? 1 : k[1] ? 2 : k[2] ? 3 : k[3] ? 4 : 0;
    sw0 = ~k[0]; sw1 = ~k[1]; sw2 = ~k[2]; sw3 = ~k[3];
    if (!m_halt) begin
      if (m_run) begin
        if (req != 0 && !opp(req, m_dir)) m_pend = req;
      end else if (req != 0) begin
        m_run = 1; m_pend = req; next_tick = cyc + 5;
      end
    end
    step();
    sw0 = 1'b1; sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1;
  endtask

  task automatic expect_tick();
    exp_t e;
    int nx, ny;
    nx = m_x; ny = m_y;
    case (m_pend)
      1: ny = (m_y == 0) ? GH - 1 : m_y - 1;
      2: ny = (m_y == GH - 1) ? 0 : m_y + 1;
      3: nx = (m_x == 0) ? GW - 1 : m_x - 1;
      4: nx = (m_x == GW - 1) ? 0 : m_x + 1;
      default: ;
    endcase
    e = '{m_pend, nx, ny, next_tick};
    sb.push_back(e);
    m_dir = m_pend; m_x = nx; m_y = ny;
    next_tick += TD;
    ticks_exp++;
  endtask

  task automatic wait_tick();
    exp_t e;
    int n;
    e = sb.pop_front();
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_now && n < 20);
    check($sformatf("tick%0d_cycle", ticks_exp), cyc, e.cyc);
    check($sformatf("tick%0d_dir", ticks_exp), direction, e.dir);
    check($sformatf("tick%0d_x", ticks_exp), head_x, e.x);
    check($sformatf("tick%0d_y", ticks_exp), head_y, e.y);
    check($sformatf("tick%0d_running", ticks_exp), running, 32'd1);
  endtask

  task automatic check_head(input string tag, input int d, input int x, input int y);
    check({tag, "_dir"}, direction, d);
    check({tag, "_x"}, head_x, x);
    check({tag, "_y"}, head_y, y);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    // 1. reset values, then an async reset in the middle of RUN
    step();
    check_head("rst", 0, X0, Y0);
    check("rst_tick", move_tick, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    step();
    reset = 1'b1;
    press(4'b1000);
    step();
    check("run_entered", running, 1);
    #2 reset = 1'b0;
    #1;
    check_head("midrun_rst", 0, X0, Y0);
    check("midrun_rst_tick", move_tick, 0);
    check("midrun_rst_running", running, 0);
    check("midrun_rst_halted", halted, 0);
    model_reset();
    step();
    reset = 1'b1;
    repeat (20) step();
    check("idle_running", running, 0);
    check("idle_ticks", ticks_seen, 0);

    // 2. start moving right, wrap x from 7 to 0
    press(4'b1000);
    repeat (4) begin
      expect_tick();
      wait_tick();
    end

    // 3. reversal rejection, last accepted wins, key priority
    press(4'b0100);
    expect_tick(); wait_tick();
    press(4'b0001);
    press(4'b0010);
    expect_tick(); wait_tick();
    press(4'b0101);
    expect_tick(); wait_tick();
    expect_tick(); wait_tick();
    press(4'b1100);
    expect_tick(); wait_tick();

    // 4. left wrap, then up wrap, then reversal judged against committed direction
    expect_tick(); wait_tick();
    press(4'b0001);
    expect_tick(); wait_tick();
    press(4'b0100);
    press(4'b1000);
    expect_tick(); wait_tick();

    // 5. pause holds the divider for 10 cycles while requests still latch
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) press(4'b0010);
      else step();
    end
    pause = 1'b0;
    next_tick += 10;
    expect_tick(); wait_tick();

    // 6. game_over on the would-be tick cycle, HALT ignores inputs, restart wins over keys
    repeat (3) step();
    game_over = 1'b1;
    m_halt = 1;
    step();
    check("halt_tick", tick_now, 0);
    check("halt_halted", halted, 1);
    check("halt_running", running, 0);
    check_head("halt", m_dir, m_x, m_y);
    pause = 1'b1;
    press(4'b0001);
    press(4'b1000);
    pause = 1'b0;
    repeat (6) step();
    game_over = 1'b0;
    repeat (3) step();
    check("halt_hold_halted", halted, 1);
    check_head("halt_hold", m_dir, m_x, m_y);
    restart = 1'b1;
    sw0 = 1'b0;
    step();
    restart = 1'b0;
    sw0 = 1'b1;
    model_reset();
    check("restart_running", running, 0);
    check("restart_halted", halted, 0);
    check_head("restart", 0, X0, Y0);
    repeat (3) step();
    check("restart_idle", running, 0);
    press(4'b0010);
    expect_tick(); wait_tick();

    check("total_ticks", ticks_seen, ticks_exp);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
